// File: rtl/ucode_sequencer_pkg.sv
`default_nettype none
// ==========================================================================
// ucode_pkg : shared state, opcode and field definitions for ucode_sequencer
// Rev 1.0
// ==========================================================================
package ucode_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    ISSUE     = 2'd2,
    WAIT_FLAG = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    VAR_MUL_IMM  = 2'd0,
    VAR_MULS_IMM = 2'd1,
    VAR_MUL_REG  = 2'd2,
    VAR_MULS_REG = 2'd3
  } mul_var_e;

  localparam logic [6:0] c_op_mul_imm  = 7'b0010000;
  localparam logic [6:0] c_op_muls_imm = 7'b0011000;
  localparam logic [6:0] c_op_mul_reg  = 7'b0110000;
  localparam logic [6:0] c_op_muls_reg = 7'b0111000;
  localparam logic [6:0] c_op_ubne     = 7'b1100001;
  localparam logic [6:0] c_op_uend     = 7'b1111111;

  localparam int c_opc_msb = 31;
  localparam int c_opc_lsb = 25;
  localparam int c_rd_msb  = 24;
  localparam int c_rd_lsb  = 21;
  localparam int c_rs1_msb = 20;
  localparam int c_rs1_lsb = 17;
  localparam int c_rs2_msb = 16;
  localparam int c_rs2_lsb = 13;
  localparam int c_imm_msb = 15;
  localparam int c_imm_lsb = 0;

  localparam int c_entry_mul_imm  = 0;
  localparam int c_entry_muls_imm = 6;
  localparam int c_entry_mul_reg  = 12;
  localparam int c_entry_muls_reg = 18;

endpackage
`default_nettype wire

// File: rtl/ucode_sequencer_if.sv
`default_nettype none
// ==========================================================================
// ucode_sequencer_if : fetch, decode, ROM, ghost-file and flag signals
// Rev 1.0
// ==========================================================================
interface ucode_sequencer_if #(
  parameter int UC_AW = 5
);
  logic [31:0]      if_instr;
  logic             if_valid;
  logic             if_ready;
  logic [31:0]      id_instr;
  logic             id_valid;
  logic             id_ready;
  logic [UC_AW-1:0] uc_addr;
  logic [31:0]      uc_data;
  logic             ghost_load;
  logic [15:0]      ghost_imm;
  logic [3:0]       ghost_rs1;
  logic [3:0]       ghost_rs2;
  logic [3:0]       ghost_rd;
  logic             flag_valid;
  logic             flag_z;
  logic             flush;
  logic             seq_busy;
  logic             err;

  modport master (
    input  if_instr, if_valid, id_ready, uc_data, flag_valid, flag_z, flush,
    output if_ready, id_instr, id_valid, uc_addr, ghost_load, ghost_imm,
           ghost_rs1, ghost_rs2, ghost_rd, seq_busy, err
  );

  modport slave (
    output if_instr, if_valid, id_ready, uc_data, flag_valid, flag_z, flush,
    input  if_ready, id_instr, id_valid, uc_addr, ghost_load, ghost_imm,
           ghost_rs1, ghost_rs2, ghost_rd, seq_busy, err
  );
endinterface
`default_nettype wire

// File: rtl/ucode_sequencer_mul_detect.sv
`default_nettype none
// ==========================================================================
// ucode_mul_detect : classifies an opcode as one of the four multiplies
// Rev 1.0
// ==========================================================================
module ucode_mul_detect
  import ucode_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_mul,
  output mul_var_e   variant
);

  always_comb begin
    is_mul  = 1'b1;
    variant = VAR_MUL_IMM;
    case (opcode)
      c_op_mul_imm:  variant = VAR_MUL_IMM;
      c_op_muls_imm: variant = VAR_MULS_IMM;
      c_op_mul_reg:  variant = VAR_MUL_REG;
      c_op_muls_reg: variant = VAR_MULS_REG;
      default:       is_mul  = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ucode_sequencer.sv
`default_nettype none
// ==========================================================================
// ucode_sequencer : passes fetch to decode, expands multiplies via microcode
// Rev 1.0
// ==========================================================================
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int UC_AW          = 5,
  parameter int UC_DEPTH       = 31,
  parameter int ENTRY_MUL_IMM  = c_entry_mul_imm,
  parameter int ENTRY_MULS_IMM = c_entry_muls_imm,
  parameter int ENTRY_MUL_REG  = c_entry_mul_reg,
  parameter int ENTRY_MULS_REG = c_entry_muls_reg
) (
  input  logic              clk,
  input  logic              rst,
  ucode_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic [UC_AW-1:0] uc_addr_q, uc_addr_d;
  logic [15:0]      ghost_imm_q, ghost_imm_d;
  logic [3:0]       ghost_rs1_q, ghost_rs1_d;
  logic [3:0]       ghost_rs2_q, ghost_rs2_d;
  logic [3:0]       ghost_rd_q, ghost_rd_d;
  logic             ghost_load_q, ghost_load_d;
  logic             err_q, err_d;
  logic             seq_busy_q, seq_busy_d;

  logic             w_is_mul;
  mul_var_e         w_variant;
  logic [UC_AW-1:0] w_entry;
  logic [6:0]       w_uc_op;
  logic [UC_AW-1:0] w_target;
  logic             w_jump;
  logic             w_if_ready;
  logic             w_id_valid;
  logic [31:0]      w_id_instr;

  function automatic logic addr_legal(input logic [UC_AW-1:0] a);
    return 32'(a) < 32'(UC_DEPTH);
  endfunction

  ucode_mul_detect u_mul_detect (
    .opcode  (bus.if_instr[c_opc_msb:c_opc_lsb]),
    .is_mul  (w_is_mul),
    .variant (w_variant)
  );

  always_comb begin
    w_entry = UC_AW'(ENTRY_MUL_IMM);
    case (w_variant)
      VAR_MUL_IMM:  w_entry = UC_AW'(ENTRY_MUL_IMM);
      VAR_MULS_IMM: w_entry = UC_AW'(ENTRY_MULS_IMM);
      VAR_MUL_REG:  w_entry = UC_AW'(ENTRY_MUL_REG);
      VAR_MULS_REG: w_entry = UC_AW'(ENTRY_MULS_REG);
      default:      w_entry = UC_AW'(ENTRY_MUL_IMM);
    endcase
  end

  assign w_uc_op = bus.uc_data[c_opc_msb:c_opc_lsb];

  always_comb begin
    state_d      = state_q;
    uc_addr_d    = uc_addr_q;
    ghost_imm_d  = ghost_imm_q;
    ghost_rs1_d  = ghost_rs1_q;
    ghost_rs2_d  = ghost_rs2_q;
    ghost_rd_d   = ghost_rd_q;
    ghost_load_d = 1'b0;
    err_d        = 1'b0;
    w_jump       = 1'b0;
    w_target     = uc_addr_q + UC_AW'(1);
    w_if_ready   = 1'b0;
    w_id_valid   = 1'b0;
    w_id_instr   = bus.uc_data;

    case (state_q)
      IDLE: begin
        w_id_instr = bus.if_instr;
        if (bus.if_valid && w_is_mul) begin
          w_if_ready   = 1'b1;
          state_d      = LOAD;
          uc_addr_d    = w_entry;
          ghost_imm_d  = bus.if_instr[c_imm_msb:c_imm_lsb];
          ghost_rs1_d  = bus.if_instr[c_rs1_msb:c_rs1_lsb];
          ghost_rs2_d  = bus.if_instr[c_rs2_msb:c_rs2_lsb];
          ghost_rd_d   = bus.if_instr[c_rd_msb:c_rd_lsb];
          ghost_load_d = 1'b1;
        end else begin
          w_id_valid = bus.if_valid;
          w_if_ready = bus.id_ready;
        end
      end
      LOAD: state_d = ISSUE;
      ISSUE: begin
        case (w_uc_op)
          c_op_ubne: state_d = WAIT_FLAG;
          c_op_uend: state_d = IDLE;
          default: begin
            w_id_valid = 1'b1;
            w_jump     = bus.id_ready;
          end
        endcase
      end
      WAIT_FLAG: begin
        // uc_addr is parked on the UBNE, so uc_data still carries its offset;
        // a UC_AW-bit add of the raw field is the sign-extended add mod 2^UC_AW.
        if (bus.flag_valid) begin
          state_d = ISSUE;
          w_jump  = 1'b1;
          if (!bus.flag_z) begin
            w_target = uc_addr_q + bus.uc_data[UC_AW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_jump) begin
      if (addr_legal(w_target)) begin
        uc_addr_d = w_target;
      end else begin
        err_d     = 1'b1;
        state_d   = IDLE;
        uc_addr_d = '0;
      end
    end

    if (bus.flush) begin
      state_d      = IDLE;
      uc_addr_d    = '0;
      ghost_imm_d  = ghost_imm_q;
      ghost_rs1_d  = ghost_rs1_q;
      ghost_rs2_d  = ghost_rs2_q;
      ghost_rd_d   = ghost_rd_q;
      ghost_load_d = 1'b0;
      err_d        = 1'b0;
      w_if_ready   = 1'b0;
      w_id_valid   = 1'b0;
    end

    seq_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      uc_addr_q    <= '0;
      ghost_imm_q  <= '0;
      ghost_rs1_q  <= '0;
      ghost_rs2_q  <= '0;
      ghost_rd_q   <= '0;
      ghost_load_q <= 1'b0;
      err_q        <= 1'b0;
      seq_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      uc_addr_q    <= uc_addr_d;
      ghost_imm_q  <= ghost_imm_d;
      ghost_rs1_q  <= ghost_rs1_d;
      ghost_rs2_q  <= ghost_rs2_d;
      ghost_rd_q   <= ghost_rd_d;
      ghost_load_q <= ghost_load_d;
      err_q        <= err_d;
      seq_busy_q   <= seq_busy_d;
    end
  end

  assign bus.if_ready   = w_if_ready;
  assign bus.id_valid   = w_id_valid;
  assign bus.id_instr   = w_id_instr;
  assign bus.uc_addr    = uc_addr_q;
  assign bus.ghost_load = ghost_load_q;
  assign bus.ghost_imm  = ghost_imm_q;
  assign bus.ghost_rs1  = ghost_rs1_q;
  assign bus.ghost_rs2  = ghost_rs2_q;
  assign bus.ghost_rd   = ghost_rd_q;
  assign bus.seq_busy   = seq_busy_q;
  assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_ucode_sequencer : directed bench with a cycle-level behavioural model
// Rev 1.0
// ==========================================================================
module tb_ucode_sequencer;

  localparam logic [6:0] OP_MUL_IMM  = 7'h10;
  localparam logic [6:0] OP_MULS_IMM = 7'h18;
  localparam logic [6:0] OP_MUL_REG  = 7'h30;
  localparam logic [6:0] OP_MULS_REG = 7'h38;
  localparam logic [6:0] OP_UBNE     = 7'h61;
  localparam logic [6:0] OP_UEND     = 7'h7F;
  localparam logic [31:0] W_UEND     = 32'hFE00_0000;
  localparam logic [31:0] W_UBNE_M3  = 32'hC200_001D;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ucode_sequencer_if #(.UC_AW(5)) bus ();

  logic [31:0] rom [32];
  assign bus.uc_data = rom[bus.uc_addr];

  ucode_sequencer #(
    .UC_AW(5), .UC_DEPTH(31),
    .ENTRY_MUL_IMM(0), .ENTRY_MULS_IMM(6), .ENTRY_MUL_REG(12), .ENTRY_MULS_REG(18)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] got [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: microprogram interpreter with its own pc and phase flags
  bit          m_busy, m_loading, m_waiting, m_err;
  int          m_pc;
  logic [15:0] m_imm;
  logic [3:0]  m_rs1, m_rs2, m_rd;

  function automatic int entry_of(input logic [6:0] op);
    case (op)
      OP_MUL_IMM:  return 0;
      OP_MULS_IMM: return 6;
      OP_MUL_REG:  return 12;
      OP_MULS_REG: return 18;
      default:     return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] w;
    logic [6:0]  wop;
    int          ent, t, off;
    bit          e_idv, e_ifr, jump;
    logic [31:0] e_instr;
    if (!rst) begin
      m_busy = 0; m_loading = 0; m_waiting = 0; m_err = 0; m_pc = 0;
      m_imm = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    end
    w   = rom[m_pc];
    wop = w[31:25];
    ent = bus.if_valid ? entry_of(bus.if_instr[31:25]) : -1;
    e_instr = w; e_idv = 0; e_ifr = 0;
    if (!m_busy) begin
      e_instr = bus.if_instr;
      if (ent >= 0) e_ifr = 1;
      else begin e_idv = bus.if_valid; e_ifr = bus.id_ready; end
    end else if (!m_loading && !m_waiting) begin
      e_idv = (wop != OP_UBNE) && (wop != OP_UEND);
    end
    if (bus.flush) begin e_idv = 0; e_ifr = 0; end

    check("id_valid", 32'(bus.id_valid), 32'(e_idv));
    check("if_ready", 32'(bus.if_ready), 32'(e_ifr));
    if (e_idv) check("id_instr", bus.id_instr, e_instr);
    check("uc_addr", 32'(bus.uc_addr), 32'(m_pc));
    check("ghost_load", 32'(bus.ghost_load), 32'(m_loading));
    check("ghost_imm", 32'(bus.ghost_imm), 32'(m_imm));
    check("ghost_regs", {20'h0, bus.ghost_rd, bus.ghost_rs1, bus.ghost_rs2},
          {20'h0, m_rd, m_rs1, m_rs2});
    check("err", 32'(bus.err), 32'(m_err));
    check("seq_busy", 32'(bus.seq_busy), 32'(m_busy));

    if (bus.id_valid && bus.id_ready && bus.seq_busy) got.push_back(bus.id_instr);

    if (rst) begin
      m_err = 0; jump = 0; t = m_pc + 1;
      if (bus.flush) begin
        m_busy = 0; m_loading = 0; m_waiting = 0; m_pc = 0;
      end else if (!m_busy) begin
        if (ent >= 0) begin
          m_imm = bus.if_instr[15:0];  m_rs2 = bus.if_instr[16:13];
          m_rs1 = bus.if_instr[20:17]; m_rd  = bus.if_instr[24:21];
          m_pc = ent; m_busy = 1; m_loading = 1;
        end
      end else if (m_loading) begin
        m_loading = 0;
      end else if (m_waiting) begin
        if (bus.flag_valid) begin
          m_waiting = 0; jump = 1;
          off = w[4] ? int'(w[4:0]) - 32 : int'(w[4:0]);
          if (!bus.flag_z) t = m_pc + off;
        end
      end else if (wop == OP_UEND) begin
        m_busy = 0;
      end else if (wop == OP_UBNE) begin
        m_waiting = 1;
      end else if (bus.id_ready) begin
        jump = 1;
      end
      if (jump) begin
        t = ((t % 32) + 32) % 32;
        if (t >= 31) begin m_err = 1; m_busy = 0; m_pc = 0; end
        else m_pc = t;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_mul(input logic [31:0] instr);
    bus.if_instr = instr;
    bus.if_valid = 1'b1;
    #2;
    check("mul accept if_ready", 32'(bus.if_ready), 32'd1);
    check("mul accept id_valid", 32'(bus.id_valid), 32'd0);
    step();
    bus.if_valid = 1'b0;
  endtask

  task automatic wait_ubne(input string name);
    for (int i = 0; i < 40; i++) begin
      if (bus.seq_busy && bus.uc_data[31:25] == OP_UBNE) return;
      step();
    end
    vectors++; miscompares++;
    $display("FAIL timeout %s: no UBNE reached, expected within 40 cycles", name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (!bus.seq_busy) return;
      step();
    end
    vectors++; miscompares++;
    $display("FAIL timeout %s: seq_busy still 1, expected 0 within 40 cycles", name);
  endtask

  logic [31:0] exp_main [10] = '{32'h0A00A000, 32'h0A00A001, 32'h0A00A002, 32'h0A00A003,
                                 32'h0A00A001, 32'h0A00A002, 32'h0A00A003,
                                 32'h0A00A001, 32'h0A00A002, 32'h0A00A003};
  logic [6:0]  var_op   [3] = '{OP_MULS_IMM, OP_MUL_REG, OP_MULS_REG};
  int          var_ent  [3] = '{6, 12, 18};
  logic [31:0] var_word [3] = '{32'h0A00A006, 32'h0A00A00C, 32'h0A00A012};
  bit          loop_z   [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h0A00A000 + 32'(i);
    rom[4] = W_UBNE_M3; rom[5] = W_UEND;
    rom[7] = W_UEND;    rom[13] = W_UEND; rom[19] = W_UEND;
    bus.if_instr = '0; bus.if_valid = 1'b0; bus.id_ready = 1'b1;
    bus.flag_valid = 1'b0; bus.flag_z = 1'b0; bus.flush = 1'b0;

    rst = 1'b0;
    repeat (2) step();
    check("reset uc_addr", 32'(bus.uc_addr), 32'd0);
    check("reset seq_busy", 32'(bus.seq_busy), 32'd0);
    check("reset ghost_load", 32'(bus.ghost_load), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    check("reset ghost_imm", 32'(bus.ghost_imm), 32'd0);
    rst = 1'b1;
    step();

    // pass-through
    bus.if_instr = 32'h0001_2345; bus.if_valid = 1'b1;
    #2;
    check("pass id_instr", bus.id_instr, 32'h0001_2345);
    check("pass id_valid", 32'(bus.id_valid), 32'd1);
    check("pass if_ready", 32'(bus.if_ready), 32'd1);
    step();
    bus.id_ready = 1'b0;
    #2;
    check("pass stalled if_ready", 32'(bus.if_ready), 32'd0);
    check("pass seq_busy", 32'(bus.seq_busy), 32'd0);
    step();
    bus.if_valid = 1'b0; bus.id_ready = 1'b1;

    // mul imm, imm=3 rs1=2 rd=5, loop program at 0..5
    got.delete();
    accept_mul(32'h20A4_0003);
    check("load ghost_load", 32'(bus.ghost_load), 32'd1);
    check("load ghost_imm", 32'(bus.ghost_imm), 32'd3);
    check("load ghost_rd", 32'(bus.ghost_rd), 32'd5);
    check("load ghost_rs1", 32'(bus.ghost_rs1), 32'd2);
    check("load uc_addr", 32'(bus.uc_addr), 32'd0);
    step();
    check("first uop ghost_load", 32'(bus.ghost_load), 32'd0);
    check("first uop id_valid", 32'(bus.id_valid), 32'd1);
    step();
    check("uop1 uc_addr", 32'(bus.uc_addr), 32'd1);
    bus.id_ready = 1'b0; bus.flag_valid = 1'b1; bus.flag_z = 1'b0;
    repeat (3) begin
      #2;
      check("stall id_instr", bus.id_instr, 32'h0A00A001);
      check("stall uc_addr", 32'(bus.uc_addr), 32'd1);
      step();
    end
    bus.id_ready = 1'b1; bus.flag_valid = 1'b0;

    foreach (loop_z[k]) begin
      wait_ubne("loop");
      check("ubne uc_addr", 32'(bus.uc_addr), 32'd4);
      step();
      step();
      check("wait hold uc_addr", 32'(bus.uc_addr), 32'd4);
      bus.flag_valid = 1'b1; bus.flag_z = loop_z[k];
      step();
      bus.flag_valid = 1'b0;
      check("branch target", 32'(bus.uc_addr), loop_z[k] ? 32'd5 : 32'd1);
    end
    bus.if_instr = 32'h0005_4321; bus.if_valid = 1'b1;
    #2;
    check("uend if_ready", 32'(bus.if_ready), 32'd0);
    check("uend id_valid", 32'(bus.id_valid), 32'd0);
    step();
    #2;
    check("after uend if_ready", 32'(bus.if_ready), 32'd1);
    check("after uend id_instr", bus.id_instr, 32'h0005_4321);
    step();
    bus.if_valid = 1'b0;
    check("loop uop count", 32'(got.size()), 32'd10);
    foreach (exp_main[k]) if (k < got.size()) check("loop uop order", got[k], exp_main[k]);

    // remaining variants: entry address and one micro-op each
    foreach (var_op[k]) begin
      got.delete();
      accept_mul({var_op[k], 4'hA, 4'h6, 4'h9, 13'h0155});
      check("variant entry", 32'(bus.uc_addr), 32'(var_ent[k]));
      check("variant ghost_imm", 32'(bus.ghost_imm), 32'h2155);
      check("variant ghost_regs", {20'h0, bus.ghost_rd, bus.ghost_rs1, bus.ghost_rs2}, 32'h0000_0A69);
      wait_idle("variant");
      step();
      check("variant uop count", 32'(got.size()), 32'd1);
      if (got.size() > 0) check("variant uop", got[0], var_word[k]);
    end

    // flush in WAIT_FLAG together with a taken flag
    accept_mul(32'h20A4_0003);
    wait_ubne("flush");
    step();
    bus.flag_valid = 1'b1; bus.flag_z = 1'b0; bus.flush = 1'b1;
    #2;
    check("flush id_valid", 32'(bus.id_valid), 32'd0);
    check("flush if_ready", 32'(bus.if_ready), 32'd0);
    step();
    bus.flag_valid = 1'b0; bus.flush = 1'b0;
    check("post flush seq_busy", 32'(bus.seq_busy), 32'd0);
    check("post flush uc_addr", 32'(bus.uc_addr), 32'd0);
    bus.if_instr = 32'h0007_7777; bus.if_valid = 1'b1;
    #2;
    check("post flush pass", bus.id_instr, 32'h0007_7777);
    step();
    bus.if_valid = 1'b0;
    step();
    check("flag discarded", 32'(bus.seq_busy), 32'd0);

    // illegal branch target 31
    rom[2] = W_UBNE_M3;
    accept_mul(32'h20A4_0003);
    wait_ubne("illegal");
    check("illegal ubne addr", 32'(bus.uc_addr), 32'd2);
    step();
    bus.flag_valid = 1'b1; bus.flag_z = 1'b0;
    step();
    bus.flag_valid = 1'b0;
    check("illegal err", 32'(bus.err), 32'd1);
    check("illegal seq_busy", 32'(bus.seq_busy), 32'd0);
    check("illegal uc_addr", 32'(bus.uc_addr), 32'd0);
    step();
    check("illegal err pulse", 32'(bus.err), 32'd0);

    // asynchronous reset mid-sequence
    accept_mul({OP_MUL_REG, 4'hA, 4'h6, 4'h9, 13'h0155});
    step();
    bus.id_ready = 1'b0;
    rst = 1'b0;
    #2;
    check("rst seq_busy", 32'(bus.seq_busy), 32'd0);
    check("rst uc_addr", 32'(bus.uc_addr), 32'd0);
    check("rst ghost_imm", 32'(bus.ghost_imm), 32'd0);
    check("rst ghost_regs", {20'h0, bus.ghost_rd, bus.ghost_rs1, bus.ghost_rs2}, 32'd0);
    step();
    rst = 1'b1; bus.id_ready = 1'b1;
    step();
    step();
    check("after rst idle", 32'(bus.seq_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
